// File: rtl/spi_led_rx.sv
// SPI mode-0 receiver that drives the board LEDs and the RGB LED from received command bytes.
// Optional MISO echo of the previously received byte: define SPI_RX_MISO_ECHO_EN.
module spi_led_rx #(
    parameter int SYNC_STAGES      = 2,
    parameter int CMD_SPLIT_EN_BIT = 7
) (
    input  logic       sys_clock,
    input  logic       sys_reset_n,
    input  logic       ck_io13,
    input  logic       ck_io11,
    input  logic       ck_io10,
    output logic       ck_io12,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [3:0] led,
    output logic       led0_r,
    output logic       led0_g,
    output logic       led0_b
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_prev;
    logic [7:0]             r_shreg;
    logic [2:0]             r_cnt;
    logic                   r_done;
    logic [7:0]             r_byte;

    logic w_sclk;
    logic w_mosi;
    logic w_cs_n;
    logic w_rise;

    // CS_n synchronizer idles high so reset never looks like a frame start
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], ck_io13};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], ck_io11};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], ck_io10};
        end
    end

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
    assign w_rise = w_sclk & ~r_sclk_prev;

    // A completed byte is staged in r_byte and published one cycle later, so
    // it survives a CS_n rise landing on the same cycle as the final SCLK rise.
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state     <= IDLE;
            r_sclk_prev <= 1'b0;
            r_shreg     <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_byte      <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_err      <= 1'b0;
            led         <= '0;
            led0_r      <= 1'b0;
            led0_g      <= 1'b0;
            led0_b      <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk;
            r_done      <= 1'b0;
            rx_valid    <= 1'b0;

            if (r_done) begin
                rx_data  <= r_byte;
                rx_valid <= 1'b1;
                if (r_byte[CMD_SPLIT_EN_BIT])
                    {led0_r, led0_g, led0_b} <= r_byte[2:0];
                else
                    led <= r_byte[3:0];
            end

            case (r_state)
                IDLE: begin
                    if (!w_cs_n) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        r_shreg <= '0;
                    end
                end
                SHIFT: begin
                    if (w_rise) begin
                        r_shreg <= {r_shreg[6:0], w_mosi};
                        r_cnt   <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_done <= 1'b1;
                            r_byte <= {r_shreg[6:0], w_mosi};
                        end
                    end
                    if (w_cs_n) begin
                        r_state <= IDLE;
                        if (r_cnt != 3'd0 && !(w_rise && r_cnt == 3'd7))
                            rx_err <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SPI_RX_MISO_ECHO_EN
    logic [7:0] r_echo_byte;
    logic [2:0] r_echo_idx;
    logic       w_fall;

    assign w_fall = ~w_sclk & r_sclk_prev;

    // r_echo_idx always points at the bit to present on the next SCLK fall
    always_ff @(posedge sys_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_echo_byte <= '0;
            r_echo_idx  <= '0;
            ck_io12     <= 1'b0;
        end else if (r_state == IDLE) begin
            ck_io12 <= 1'b0;
            if (!w_cs_n) begin
                r_echo_byte <= rx_data;
                r_echo_idx  <= 3'd6;
                ck_io12     <= rx_data[7];
            end
        end else if (w_cs_n) begin
            ck_io12 <= 1'b0;
        end else if (w_fall) begin
            ck_io12    <= r_echo_byte[r_echo_idx];
            r_echo_idx <= r_echo_idx - 3'd1;
        end
    end
`else
    assign ck_io12 = 1'b0;
`endif

endmodule

// File: doc/spi_led_rx.md
SPI_LED_RX -- requirements
Module: spi_led_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronizer on SCLK/MOSI/CS (legal range 2..4).
REQ-002 Parameter CMD_SPLIT_EN_BIT, default 7: bit index in a received byte that selects the RGB command over the LED command.
REQ-003 sys_clock  in  1  sole clock; all state is on its rising edge.
REQ-004 sys_reset_n  in  1  reset, asynchronous and active-low.
REQ-005 ck_io13  in  1  SPI SCLK from the external controller, asynchronous to sys_clock; SPI mode 0.
REQ-006 ck_io11  in  1  SPI MOSI, asynchronous to sys_clock; MSB first.
REQ-007 ck_io10  in  1  SPI CS_n, asynchronous to sys_clock; active-low frame enable.
REQ-008 ck_io12  out  1  SPI MISO echo, per the Configuration section.
REQ-009 rx_data  out  8  last complete received byte.
REQ-010 rx_valid  out  1  one-cycle strobe marking an update of rx_data.
REQ-011 rx_err  out  1  sticky flag: a frame ended with a partial byte.
REQ-012 led  out  4  board LEDs.
REQ-013 led0_r, led0_g, led0_b  out  1 each  RGB LED channels.

Function
REQ-014 SCLK, MOSI and CS_n shall each pass through a SYNC_STAGES-deep synchronizer; all logic after that uses only the synchronized copies.
REQ-015 SCLK rise and fall events shall come from a registered copy of synchronized SCLK: rise = prev 0 and now 1; fall = prev 1 and now 0.
REQ-016 States: IDLE and SHIFT.
  - IDLE -> SHIFT on synchronized CS_n = 0.
  - SHIFT -> IDLE on synchronized CS_n = 1.
REQ-017 In SHIFT, on each SCLK rise:
  - synchronized MOSI shifts into an 8-bit shift register at the LSB end (MSB-first order);
  - a 3-bit bit counter increments and wraps 7 -> 0.
REQ-018 When the counter wraps 7 -> 0:
  - the completed byte loads into rx_data;
  - rx_valid is high for exactly the next cycle.
  - Latency is fixed: SYNC_STAGES+1 sys_clock cycles after the first sys_clock edge at which raw SCLK is sampled high.
REQ-019 Multiple bytes per frame shall be accepted back-to-back without returning to IDLE.
REQ-020 SCLK edges while in IDLE shall be ignored. The bit counter and shift register shall clear on IDLE -> SHIFT.
REQ-021 CS_n rising with a nonzero bit counter shall:
  - discard the partial byte;
  - set rx_err;
  - leave rx_data unchanged and not pulse rx_valid.
  rx_err clears only on reset.
REQ-022 Command decode, in the same cycle rx_valid is high:
  - byte bit CMD_SPLIT_EN_BIT = 0: led <= byte[3:0];
  - bit = 1: {led0_r, led0_g, led0_b} <= byte[2:0].
  - All other bits are ignored.
REQ-023 If a CS_n rise and the final SCLK rise are synchronized in the same cycle, the byte completes (REQ-018) and rx_err is not set.
REQ-024 Timing requirement on the controller: SCLK high and low phases each ≥ SYNC_STAGES+2 sys_clock periods. Faster SCLK is out of contract.

Reset
REQ-025 While sys_reset_n = 0:
  - state = IDLE;
  - counter, shift register, rx_data, led = 0;
  - rx_valid, rx_err, led0_r/g/b, ck_io12 = 0;
  - synchronizer flops = 1 for CS_n and 0 for SCLK/MOSI.
REQ-026 Reset asserted mid-frame aborts the byte silently (no rx_err). After release, the block waits in IDLE for the next CS_n falling edge.

Configuration
REQ-027 Macro SPI_RX_MISO_ECHO_EN.
  - Defined: during SHIFT, ck_io12 drives the previous rx_data MSB first.
    - Bit 7 is presented at IDLE -> SHIFT.
    - The next bit is presented on each synchronized SCLK fall.
    - The bit index wraps every 8 bits.
    - ck_io12 = 0 in IDLE.
  - Undefined: ck_io12 is tied to 0 and the echo logic is absent.

Verification
REQ-028 Bench coverage:
  - Reset, then send 0x05 (SCLK period 16 sys_clock cycles) -> rx_valid pulses once, rx_data = 0x05, led = 4'b0101, RGB = 000, rx_err = 0.
  - Frame 0x83 then 0x0A under one CS_n -> two rx_valid pulses; RGB = r0 g1 b1, then led = 4'b1010.
  - CS_n high after 5 bits of 0xFF -> rx_err = 1, no rx_valid, rx_data/led unchanged; the next full byte 0x01 still gives led = 4'b0001.
  - SCLK toggled 8 times with CS_n high -> no rx_valid, state stays IDLE.
  - sys_reset_n pulsed low after 4 bits -> all outputs 0; a following byte 0x0F gives led = 4'b1111, rx_err = 0.
  - SPI_RX_MISO_ECHO_EN defined: send 0xA5, then 0x00 -> MISO bits in the second frame are 1,0,1,0,0,1,0,1.
